// File: rtl/capture_trigger.sv
// Logic-analyzer capture/trigger stage: synchronizes and decimates the channel word, streams samples
// into a circular buffer and stops a programmed number of samples after a mask/value trigger.
// Optional macro CAPTURE_FORCE_TRIG_EN adds a force_trig input that forces the next PRE strobe to trigger.
module capture_trigger #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 12,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [WIDTH-1:0]  trig_mask,
  input  logic [WIDTH-1:0]  trig_value,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [WIDTH-1:0]  din,
`ifdef CAPTURE_FORCE_TRIG_EN
  input  logic              force_trig,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_POST,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [WIDTH-1:0]  sync1;
  logic [WIDTH-1:0]  samp;
  logic [DIV_W-1:0]  count;
  logic              prev_match;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] next_addr;

  logic              active;
  logic              strobe;
  logic              match;
  logic              hit;
  logic              trig_hit;
  logic              do_write;
  logic              do_trig;

  assign active = (state == ST_PRE) || (state == ST_POST);
  // arm/abort pre-empt the strobe of their own cycle so no stale sample leaks into a new capture
  assign strobe = active && (count == rate_div) && !arm && !abort;
  assign match  = ((samp ^ trig_value) & trig_mask) == '0;
  assign hit    = trig_edge ? (match & ~prev_match) : match;

  // wr_addr holds the address of the write on the bus, so the next write lands one past it
  assign next_addr = wr_en ? (wr_addr + ADDR_W'(1)) : wr_addr;

`ifdef CAPTURE_FORCE_TRIG_EN
  logic force_pend;

  assign trig_hit = hit | force_pend | force_trig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      force_pend <= 1'b0;
    end else if (abort || arm || (state != ST_PRE)) begin
      force_pend <= 1'b0;
    end else if (strobe) begin
      force_pend <= 1'b0;
    end else if (force_trig) begin
      force_pend <= 1'b1;
    end
  end
`else
  assign trig_hit = hit;
`endif

  assign busy = active;
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    do_write   = 1'b0;
    do_trig    = 1'b0;
    if (abort) begin
      next_state = ST_IDLE;
    end else if (arm) begin
      next_state = ST_PRE;
    end else begin
      case (state)
        ST_PRE: begin
          if (strobe) begin
            do_write = 1'b1;
            if (trig_hit) begin
              do_trig    = 1'b1;
              next_state = (post_count == '0) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (strobe) begin
            do_write = 1'b1;
            if (remaining == ADDR_W'(1)) begin
              next_state = ST_DONE;
            end
          end
        end
        default: begin
          next_state = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= '0;
      samp       <= '0;
      count      <= '0;
      prev_match <= 1'b0;
      remaining  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      trig_addr  <= '0;
    end else begin
      sync1 <= din;
      samp  <= sync1;
      if (abort) begin
        wr_en      <= 1'b0;
        count      <= '0;
        prev_match <= 1'b0;
      end else if (arm) begin
        wr_en      <= 1'b0;
        wr_addr    <= '0;
        remaining  <= post_count;
        count      <= '0;
        prev_match <= 1'b0;
      end else begin
        wr_en   <= do_write;
        wr_addr <= next_addr;
        if (do_write) begin
          wr_data <= samp;
        end
        if (do_trig) begin
          trig_addr <= next_addr;
        end
        if (!active || (count == rate_div)) begin
          count <= '0;
        end else begin
          count <= count + DIV_W'(1);
        end
        if (strobe) begin
          prev_match <= match;
        end
        if ((state == ST_POST) && do_write) begin
          remaining <= remaining - ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_capture_trigger.sv
// Self-checking bench for capture_trigger (ADDR_W=4): expected buffer writes are queued when a capture
// is set up and compared as the DUT emits them; status outputs are checked at key points.
module tb_capture_trigger;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              arm;
  logic              abort;
  logic [DIV_W-1:0]  rate_div;
  logic [WIDTH-1:0]  trig_mask;
  logic [WIDTH-1:0]  trig_value;
  logic              trig_edge;
  logic [ADDR_W-1:0] post_count;
  logic [WIDTH-1:0]  din;
  logic              force_trig;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] trig_addr;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W+WIDTH-1:0] expQ[$];
  logic [ADDR_W+WIDTH-1:0] expWr;
  bit  intervalOn = 1'b0;
  int  testId     = 0;
  int  lastTest   = -1;
  int  cyc        = 0;
  int  lastCyc    = 0;

  capture_trigger #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .abort      (abort),
    .rate_div   (rate_div),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .trig_edge  (trig_edge),
    .post_count (post_count),
    .din        (din),
`ifdef CAPTURE_FORCE_TRIG_EN
    .force_trig (force_trig),
`endif
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .trig_addr  (trig_addr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DIV_W-1:0] rd, input logic [WIDTH-1:0] mask,
                               input logic [WIDTH-1:0] value, input logic edgeMode,
                               input logic [ADDR_W-1:0] post, input logic [WIDTH-1:0] data);
    rate_div   = rd;
    trig_mask  = mask;
    trig_value = value;
    trig_edge  = edgeMode;
    post_count = post;
    din        = data;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulseArm();
    testId++;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pushWrite(input int addr, input logic [WIDTH-1:0] data);
    expQ.push_back({ADDR_W'(addr), data});
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'b0, done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    force_trig = 1'b0;
    rate_div = '0;
    trig_mask = '0;
    trig_value = '0;
    trig_edge = 1'b0;
    post_count = '0;
    din = '0;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (wr_en === 1'b1) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedWrite", 32'd1, 32'd0);
          end else begin
            expWr = expQ.pop_front();
            checkOutput("wrAddrData", {20'b0, wr_addr, wr_data}, {20'b0, expWr});
          end
          if (intervalOn) begin
            if (lastTest == testId) checkOutput("wrInterval", 32'(cyc - lastCyc), 32'd4);
            lastTest = testId;
            lastCyc  = cyc;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {18'b0, wr_en, wr_addr, wr_data, trig_addr, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // level trigger on A5 arriving at sample 5, three post samples
    applyStimulus(16'd0, 8'hFF, 8'hA5, 1'b0, 4'd3, 8'h00);
    for (int a = 0; a < 5; a++) pushWrite(a, 8'h00);
    for (int a = 5; a < 9; a++) pushWrite(a, 8'hA5);
    pulseArm();
    checkOutput("t1Busy", {31'b0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    din = 8'hA5;
    waitDone("t1Done", 40);
    checkOutput("t1TrigAddr", {28'b0, trig_addr}, 32'd5);
    @(negedge clk);
    checkOutput("t1WrEnAfter", {31'b0, wr_en}, 32'd0);
    checkOutput("t1DoneHeld", {30'b0, busy, done}, 32'd1);
    checkOutput("t1QueueEmpty", 32'(expQ.size()), 32'd0);

    // edge trigger on bit 0 with decimation by 4
    applyStimulus(16'd3, 8'h01, 8'h01, 1'b1, 4'd2, 8'hFE);
    for (int a = 0; a < 3; a++) pushWrite(a, 8'hFE);
    for (int a = 3; a < 6; a++) pushWrite(a, 8'hFF);
    intervalOn = 1'b1;
    pulseArm();
    repeat (12) @(negedge clk);
    checkOutput("t2NoTrigYet", {26'b0, busy, done, trig_addr}, {26'b0, 1'b1, 1'b0, 4'd5});
    din = 8'hFF;
    waitDone("t2Done", 60);
    intervalOn = 1'b0;
    checkOutput("t2TrigAddr", {28'b0, trig_addr}, 32'd3);
    @(negedge clk);
    checkOutput("t2QueueEmpty", 32'(expQ.size()), 32'd0);

    // no match: address wraps through the circular buffer
    applyStimulus(16'd0, 8'hFF, 8'h5A, 1'b0, 4'd1, 8'h00);
    for (int i = 0; i < 21; i++) pushWrite(i % 16, 8'h00);
    pulseArm();
    repeat (21) @(negedge clk);
    checkOutput("t3WrapAddr", {28'b0, wr_addr}, 32'd4);
    checkOutput("t3BusyDone", {30'b0, busy, done}, 32'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t3AbortIdle", {30'b0, wr_en, busy}, 32'd0);
    checkOutput("t3QueueEmpty", 32'(expQ.size()), 32'd0);

    // mask 0, post 0: trigger on the first sample and finish immediately
    applyStimulus(16'd0, 8'h00, 8'h00, 1'b0, 4'd0, 8'h3C);
    pushWrite(0, 8'h3C);
    pulseArm();
    @(negedge clk);
    checkOutput("t4DoneNext", {30'b0, busy, done}, 32'd1);
    checkOutput("t4TrigAddr", {28'b0, trig_addr}, 32'd0);
    @(negedge clk);
    checkOutput("t4SingleWrite", {31'b0, wr_en}, 32'd0);
    checkOutput("t4QueueEmpty", 32'(expQ.size()), 32'd0);

    // arm and abort together in PRE: abort wins
    applyStimulus(16'd0, 8'hFF, 8'hA5, 1'b0, 4'd2, 8'h00);
    pushWrite(0, 8'h00);
    pulseArm();
    @(negedge clk);
    arm = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    abort = 1'b0;
    checkOutput("t5ArmAbort", {29'b0, wr_en, busy, done}, 32'd0);

    // reset in the middle of POST
    applyStimulus(16'd0, 8'hFF, 8'hA5, 1'b0, 4'd8, 8'hA5);
    pushWrite(0, 8'hA5);
    pushWrite(1, 8'hA5);
    pulseArm();
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5InPost", {30'b0, busy, done}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t5ResetOutputs", {18'b0, wr_en, wr_addr, wr_data, trig_addr, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t5QueueEmpty", 32'(expQ.size()), 32'd0);

`ifdef CAPTURE_FORCE_TRIG_EN
    // forced trigger while the real value never appears
    applyStimulus(16'd0, 8'hFF, 8'h5A, 1'b0, 4'd1, 8'h00);
    for (int a = 0; a < 4; a++) pushWrite(a, 8'h00);
    pulseArm();
    @(negedge clk);
    @(negedge clk);
    force_trig = 1'b1;
    @(negedge clk);
    force_trig = 1'b0;
    waitDone("t6Done", 20);
    checkOutput("t6TrigAddr", {28'b0, trig_addr}, 32'd2);
    @(negedge clk);
    checkOutput("t6QueueEmpty", 32'(expQ.size()), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
